cipher_cfg_loader: RTL
======================

CIPHER_CFG_LOADER -- requirements
Module: cipher_cfg_loader

Interface
REQ-001 Parameter: M, default 40, length in bits of the cipher configuration chain (key length).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-005 Port: key  input  M  key to program; captured on the cycle start is accepted.
REQ-006 Port: verify  input  1  captured with start; 1 adds a readback pass after the load.
REQ-007 Port: abort  input  1  synchronous cancel; returns the block to IDLE.
REQ-008 Port: cfg_en  output  1  chain shift enable; each rising edge with cfg_en=1 shifts the chain once.
REQ-009 Port: cfg_i  output  1  serial data into the chain, MSB first.
REQ-010 Port: cfg_o  input  1  serial data from the chain's last stage.
REQ-011 Port: busy  output  1  high in LOAD and VERIFY.
REQ-012 Port: done  output  1  single-cycle completion pulse.
REQ-013 Port: match  output  1  readback result; valid from the done cycle until the next accepted start.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD, VERIFY and DONE.
REQ-015 IDLE with start=1 SHALL capture key into shift register sr and verify into a flag, clear bit counter cnt, and enter LOAD next cycle.
REQ-016 In LOAD, cfg_en SHALL be 1 and cfg_i SHALL equal sr[M-1]; sr SHALL shift left by one and cnt SHALL increment on every cycle.
REQ-017 LOAD SHALL last exactly M cycles (cnt 0..M-1); at cnt=M-1 the next state SHALL be VERIFY if the flag is set, else DONE.
REQ-018 On entering VERIFY, sr SHALL be reloaded with the captured key (a separate key_q register) and cnt SHALL be cleared.
REQ-019 VERIFY SHALL last exactly M cycles; cfg_en=1, cfg_i=sr[M-1], and cfg_o SHALL be sampled on each shifting edge into readback register rb (shift in at LSB).
REQ-020 After VERIFY, rb SHALL equal key_q for a correct chain; match SHALL be set to (rb == key_q).
REQ-021 When verify=0, match SHALL be set to 1 at DONE.
REQ-022 DONE SHALL last one cycle with done=1, cfg_en=0, busy=0, then return to IDLE.
REQ-023 Latency: an accepted start at cycle T SHALL give cfg_en high for cycles T+1..T+M (plus T+M+1..T+2M with verify), with done at T+M+1 (T+2M+1 with verify).
REQ-024 start outside IDLE SHALL be ignored, with no effect on key_q, the flag or the counters.
REQ-025 start and abort in the same IDLE cycle SHALL leave the block in IDLE (abort wins).
REQ-026 abort in LOAD or VERIFY SHALL force IDLE next cycle with cfg_en=0, no done pulse and match=0; the chain is left partially shifted.
REQ-027 cfg_en SHALL be 0 in IDLE and DONE; cfg_i SHALL be 0 whenever cfg_en=0.
REQ-028 cnt SHALL be ceil(log2(M+1)) bits wide and SHALL never exceed M-1 while shifting.

Reset
REQ-029 rst=0 SHALL asynchronously force the state to IDLE; cnt, sr, key_q, rb and the flag to 0; and cfg_en, cfg_i, busy, done and match to 0.
REQ-030 The release of rst SHALL take effect on the next rising clk edge; no shifting SHALL occur in the release cycle.

Structure
REQ-031 A shared package SHALL hold the default M (40) and the state enumeration.
REQ-032 The block SHALL be a single module with no sub-modules; the shift, counter and compare logic SHALL be inline.

Verification
REQ-033 M=40, key=40'hA50F3C96E1, verify=0, start at T: cfg_i over 40 cycles = key MSB first, cfg_en high for exactly 40 cycles, done at T+41, match=1.
REQ-034 Same key with verify=1, bench chain model as a 40-bit shift register: 80 shift cycles, done at T+81, match=1, model content = 40'hA50F3C96E1.
REQ-035 verify=1 with the bench chain model flipping bit 7 during VERIFY: match=0 on the done cycle.
REQ-036 abort at LOAD cycle 10: cfg_en=0 on the next cycle, no done pulse, busy=0, match=0; a new start then completes normally.
REQ-037 start pulses during LOAD: no restart; total shift count = 40 and key_q unchanged.
REQ-038 rst=0 at VERIFY cycle 20: all outputs 0 immediately, without waiting for a clk edge; after release, state is IDLE and the next start begins at cnt=0.

Source files
------------

// File: rtl/cipher_cfg_loader_pkg.sv
// Shared definitions for the cipher configuration chain loader.
// Holds the default chain length and the loader state encoding.
package cipher_cfg_loader_pkg;

   localparam int M_DEFAULT = 40;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE
   } state_e;

endpackage

// File: rtl/cipher_cfg_loader.sv
// Serially loads an M-bit key into a cipher config chain, MSB first,
// with an optional readback pass that compares the chain against the key.
// Ports: clk, rst (async low), start/key/verify/abort requests,
// cfg_en/cfg_i drive the chain, cfg_o reads it, busy/done/match status.
module cipher_cfg_loader
   import cipher_cfg_loader_pkg::*;
#(
   parameter int M = M_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [M-1:0] key,
   input  logic         verify,
   input  logic         abort,
   output logic         cfg_en,
   output logic         cfg_i,
   input  logic         cfg_o,
   output logic         busy,
   output logic         done,
   output logic         match
);

   localparam int CW = $clog2(M + 1);

   state_e        state_q;
   logic [M-1:0]  sr_q;
   logic [M-1:0]  key_q;
   logic [M-1:0]  rb_q;
   logic [M-1:0]  rb_d;
   logic [CW-1:0] cnt_q;
   logic          vfy_q;
   logic          cfg_en_q;
   logic          busy_q;
   logic          done_q;
   logic          match_q;
   logic          cnt_last;

   assign cnt_last = (cnt_q == CW'(M - 1));
   // readback value including the bit sampled on this edge
   assign rb_d     = {rb_q[M-2:0], cfg_o};

   assign cfg_en = cfg_en_q;
   assign cfg_i  = cfg_en_q & sr_q[M-1];
   assign busy   = busy_q;
   assign done   = done_q;
   assign match  = match_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         key_q    <= '0;
         rb_q     <= '0;
         cnt_q    <= '0;
         vfy_q    <= 1'b0;
         cfg_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         match_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // abort has priority over a coincident start
               if (start && !abort) begin
                  sr_q     <= key;
                  key_q    <= key;
                  vfy_q    <= verify;
                  cnt_q    <= '0;
                  rb_q     <= '0;
                  match_q  <= 1'b0;
                  cfg_en_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            LOAD, VERIFY: begin
               if (abort) begin
                  cnt_q    <= '0;
                  cfg_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  match_q  <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  sr_q <= sr_q << 1;
                  if (state_q == VERIFY) rb_q <= rb_d;
                  if (!cnt_last) begin
                     cnt_q <= cnt_q + CW'(1);
                  end else begin
                     cnt_q <= '0;
                     if (state_q == LOAD && vfy_q) begin
                        // second pass re-shifts the key to push the
                        // loaded contents out through cfg_o
                        sr_q    <= key_q;
                        state_q <= VERIFY;
                     end else begin
                        cfg_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        match_q  <= (state_q == LOAD) ? 1'b1
                                    : (rb_d == key_q);
                        state_q  <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
